// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake into a small
// FIFO whose head feeds ID, and handles ID stalls plus branch redirects with one delay slot.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        cu_wpcir,
    input  logic        cu_branch,
    input  logic [31:0] ID_new_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number
);
    localparam logic [2:0] DEPTH = 3'(FBUF_DEPTH);

    // Storage is sized for the largest depth; only the first FBUF_DEPTH slots are used.
    logic [31:0] inst_mem [4];
    logic [31:0] pc4_mem  [4];
    logic [3:0]  type_mem [4];
    logic [3:0]  seq_mem  [4];

    logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, pend_pc_q, pend_pc_d;
    logic        req_q, req_d, stale_q, stale_d, pend_q, pend_d;
    logic [3:0]  seq_q, seq_d, last_num_q, last_num_d;

    logic        head_valid, accept, branch_take, ack_ev, flush, push, redir_now, keep_req;
    logic [31:0] target, redir_pc, pc_base;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [3:0] inst_class(input logic [31:0] w);
        case (w[31:26])
            6'b000000:            return 4'd1;
            6'b100011:            return 4'd2;
            6'b101011:            return 4'd3;
            6'b000100, 6'b000101: return 4'd4;
            6'b000010, 6'b000011: return 4'd5;
            default:              return 4'd6;
        endcase
    endfunction

    always_comb begin
        head_valid  = (count_q != 3'd0);
        accept      = head_valid && !cu_wpcir;
        branch_take = cu_branch && !cu_wpcir;
        target      = ID_new_pc & 32'hFFFF_FFFC;
        ack_ev      = req_q && imem_ack;
        // A taken branch with a head present consumes the delay slot now: drop the rest.
        flush       = branch_take && head_valid;
        push        = ack_ev && !stale_q && !flush;
        // Without a head, the next instruction that lands is the delay slot; redirect then.
        redir_now   = flush || (push && (pend_q || branch_take));
        redir_pc    = branch_take ? target : pend_pc_q;
        pc_base     = redir_now ? redir_pc : pc_q;
        keep_req    = req_q && !ack_ev;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
            if (accept) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + {2'b00, push} - {2'b00, accept};
        end

        pend_d    = redir_now ? 1'b0 : (branch_take ? 1'b1 : pend_q);
        pend_pc_d = branch_take ? target : pend_pc_q;
        // A request redirected away while in flight keeps its address; its data is dropped.
        stale_d   = ack_ev ? 1'b0 : (stale_q || (flush && req_q));
        seq_d     = seq_q + {3'b000, push};
        last_num_d = head_valid ? seq_mem[rd_ptr_q] : last_num_q;

        req_d  = 1'b0;
        addr_d = addr_q;
        pc_d   = pc_base;
        if (keep_req) begin
            req_d = 1'b1;
        end else if (count_d < DEPTH) begin
            req_d  = 1'b1;
            addr_d = pc_base;
            pc_d   = pc_base + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            pc_q       <= RESET_PC;
            addr_q     <= 32'd0;
            pend_pc_q  <= 32'd0;
            req_q      <= 1'b0;
            stale_q    <= 1'b0;
            pend_q     <= 1'b0;
            seq_q      <= 4'd0;
            last_num_q <= 4'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            pend_pc_q  <= pend_pc_d;
            req_q      <= req_d;
            stale_q    <= stale_d;
            pend_q     <= pend_d;
            seq_q      <= seq_d;
            last_num_q <= last_num_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rdata;
            pc4_mem[wr_ptr_q]  <= addr_q + 32'd4;
            type_mem[wr_ptr_q] <= inst_class(imem_rdata);
            seq_mem[wr_ptr_q]  <= seq_q;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign if_valid      = head_valid;
    assign if_inst       = head_valid ? inst_mem[rd_ptr_q] : 32'd0;
    assign if_pc4        = head_valid ? pc4_mem[rd_ptr_q]  : 32'd0;
    assign IF_ins_type   = head_valid ? type_mem[rd_ptr_q] : 4'd0;
    assign IF_ins_number = head_valid ? seq_mem[rd_ptr_q]  : last_num_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a latency-programmable memory responder and a
// scoreboard of expected instructions that is checked whenever ID accepts a head.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, cu_wpcir, cu_branch, if_valid;
    logic [31:0] imem_addr, imem_rdata, ID_new_pc, if_inst, if_pc4;
    logic [3:0]  IF_ins_type, IF_ins_number;

    int lat = 0;
    int wait_cnt = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] pc4;
        int          tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0), .FBUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .cu_wpcir(cu_wpcir), .cu_branch(cu_branch), .ID_new_pc(ID_new_pc),
        .if_inst(if_inst), .if_pc4(if_pc4), .if_valid(if_valid),
        .IF_ins_type(IF_ins_type), .IF_ins_number(IF_ins_number)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] op;
        if (a == 32'h0) return 32'h2001_0005;
        case (a[4:2])
            3'd0: op = 6'b000000;
            3'd1: op = 6'b100011;
            3'd2: op = 6'b101011;
            3'd3: op = 6'b000100;
            3'd4: op = 6'b000101;
            3'd5: op = 6'b000010;
            3'd6: op = 6'b000011;
            default: op = 6'b001101;
        endcase
        return {op, a[27:2]};
    endfunction

    function automatic logic [3:0] exp_type(input logic [31:0] w);
        case (w[31:26])
            6'b000000: return 4'd1;
            6'b100011: return 4'd2;
            6'b101011: return 4'd3;
            6'b000100, 6'b000101: return 4'd4;
            6'b000010, 6'b000011: return 4'd5;
            default: return 4'd6;
        endcase
    endfunction

    // Memory responder: acks after 'lat' waiting cycles (0 = same cycle as the request).
    assign imem_ack   = imem_req && (wait_cnt == lat);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic sb_push(input logic [31:0] pc4, input int tag);
        exp_t e;
        e.pc4 = pc4;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Each head taken by ID is one transaction, compared against the scoreboard front.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if_valid && !cu_wpcir) begin
            $display("accept pc4=%h inst=%h type=%0d num=%0d", if_pc4, if_inst, IF_ins_type, IF_ins_number);
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("acc_pc4", if_pc4, e.pc4);
                check("acc_inst", if_inst, mem_word(e.pc4 - 32'd4));
                check("acc_type", {28'd0, IF_ins_type}, {28'd0, exp_type(mem_word(e.pc4 - 32'd4))});
                if (e.tag >= 0) check("acc_num", {28'd0, IF_ins_number}, 32'(e.tag));
            end
        end
    end

    task automatic drain(input string tag);
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) break;
            cu_wpcir = 1'b0;
        end
        cu_wpcir = 1'b1;
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input int l);
        @(posedge clk); #1;
        rst_n = 1'b0; cu_wpcir = 1'b1; cu_branch = 1'b0; lat = l;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found, done, seen, since;
        cu_wpcir = 1'b1; cu_branch = 1'b0; ID_new_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_inst", if_inst, 32'd0);
        check("rst_pc4", if_pc4, 32'd0);
        check("rst_type", {28'd0, IF_ins_type}, 32'd0);
        check("rst_num", {28'd0, IF_ins_number}, 32'd0);

        // Reset release, zero-wait memory, ID stalled.
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t1_req", {31'd0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        check("t1_not_yet_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        check("t1_valid", {31'd0, if_valid}, 32'd1);
        check("t1_inst", if_inst, 32'h2001_0005);
        check("t1_pc4", if_pc4, 32'h4);
        check("t1_type", {28'd0, IF_ins_type}, 32'd6);
        check("t1_num", {28'd0, IF_ins_number}, 32'd0);
        @(negedge clk);
        check("t2_req_drop_full", {31'd0, imem_req}, 32'd0);
        check("t2_hold_pc4", if_pc4, 32'h4);
        @(negedge clk);
        check("t2_hold_pc4_b", if_pc4, 32'h4);
        check("t2_hold_num", {28'd0, IF_ins_number}, 32'd0);

        // Release the stall; park with head pc4=0x14 and 0x18 buffered, then branch.
        sb_push(32'h4, 0); sb_push(32'h8, 1); sb_push(32'hC, 2); sb_push(32'h10, 3); sb_push(32'h14, 4);
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (if_valid && if_pc4 == 32'h14) begin cu_wpcir = 1'b1; found = 1; break; end
            cu_wpcir = 1'b0;
        end
        check("t3_reach_0x14", 32'(found), 32'd1);
        @(posedge clk); #1;
        check("t3_head_held", if_pc4, 32'h14);
        cu_wpcir = 1'b0; cu_branch = 1'b1; ID_new_pc = 32'h100;
        sb_push(32'h104, -1); sb_push(32'h108, -1); sb_push(32'h10C, -1);
        @(posedge clk); #1;
        cu_branch = 1'b0;
        check("t3_flushed_empty", {31'd0, if_valid}, 32'd0);
        check("t3_empty_inst", if_inst, 32'd0);
        check("t3_empty_pc4", if_pc4, 32'd0);
        check("t3_empty_type", {28'd0, IF_ins_type}, 32'd0);
        check("t3_empty_num_held", {28'd0, IF_ins_number}, 32'd4);
        check("t3_target_addr", imem_addr, 32'h100);
        drain("t3_drain");

        // Latency 3, branch while head empty: 0x20 is the delay slot and is delivered.
        do_reset(3);
        for (int i = 1; i <= 9; i++) sb_push(32'(4 * i), i - 1);
        sb_push(32'h204, 9); sb_push(32'h208, 10);
        done = 0; seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            cu_branch = 1'b0;
            if (sb.size() == 0) break;
            cu_wpcir = 1'b0;
            if (!done && imem_req && imem_addr == 32'h20 && !if_valid) begin
                cu_branch = 1'b1; ID_new_pc = 32'h203; done = 1;
            end else if (done && !seen && imem_addr != 32'h20) begin
                seen = 1;
                check("t4a_target_addr", imem_addr, 32'h200);
            end
        end
        cu_wpcir = 1'b1; cu_branch = 1'b0;
        check("t4a_branch_fired", 32'(done), 32'd1);
        check("t4a_addr_moved", 32'(seen), 32'd1);
        check("t4a_drain", 32'(sb.size()), 32'd0);

        // Latency 3, branch while head valid: in-flight 0x20 is stale and discarded.
        do_reset(3);
        for (int i = 1; i <= 8; i++) sb_push(32'(4 * i), i - 1);
        sb_push(32'h204, 8); sb_push(32'h208, 9);
        done = 0; seen = 0; since = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            cu_branch = 1'b0;
            if (sb.size() == 0) break;
            cu_wpcir = 1'b0;
            if (done) since++;
            if (!done && imem_req && imem_addr == 32'h20 && if_valid && if_pc4 == 32'h20) begin
                cu_branch = 1'b1; ID_new_pc = 32'h200; done = 1;
            end else if (done && since == 1) begin
                check("t4b_req_held", {31'd0, imem_req}, 32'd1);
                check("t4b_addr_held", imem_addr, 32'h20);
            end else if (done && !seen && imem_addr != 32'h20) begin
                seen = 1;
                check("t4b_target_addr", imem_addr, 32'h200);
            end
        end
        cu_wpcir = 1'b1; cu_branch = 1'b0;
        check("t4b_branch_fired", 32'(done), 32'd1);
        check("t4b_addr_moved", 32'(seen), 32'd1);
        check("t4b_drain", 32'(sb.size()), 32'd0);

        // 17 sequential fetches: sequence tag wraps 15 -> 0.
        do_reset(0);
        for (int i = 1; i <= 17; i++) sb_push(32'(4 * i), (i - 1) % 16);
        drain("t5_drain");

        // Reset while a request is in flight.
        do_reset(3);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (imem_req && if_valid) begin found = 1; break; end
        end
        check("t6_setup", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_req_drop", {31'd0, imem_req}, 32'd0);
        check("t6_valid_drop", {31'd0, if_valid}, 32'd0);
        check("t6_pc4_zero", if_pc4, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (imem_req) begin found = 1; break; end
        end
        check("t6_refetch_req", 32'(found), 32'd1);
        check("t6_refetch_addr", imem_addr, 32'h0);
        sb_push(32'h4, 0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
